// File: rtl/univ_shift_pkg.sv
// ----------------------------------------------------------------------------
// univ_shift_pkg
// Shared definitions for the universal shift/rotate register:
//   - 3-bit operation encodings (MODE_HOLD .. MODE_CLR)
//   - burst FSM state encoding
//   - is_burst_op(): which modes may be repeated by the burst engine
// ----------------------------------------------------------------------------
package univ_shift_pkg;

    localparam logic [2:0] MODE_HOLD = 3'b000;
    localparam logic [2:0] MODE_SHR  = 3'b001;
    localparam logic [2:0] MODE_SHL  = 3'b010;
    localparam logic [2:0] MODE_ROR  = 3'b011;
    localparam logic [2:0] MODE_ROL  = 3'b100;
    localparam logic [2:0] MODE_LOAD = 3'b101;
    localparam logic [2:0] MODE_ASR  = 3'b110;
    localparam logic [2:0] MODE_CLR  = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } state_t;

    // Only the shifts and rotates are meaningful to repeat; hold, load and
    // clear give the same result however many times they are applied.
    function automatic logic is_burst_op(input logic [2:0] m);
        return (m == MODE_SHR) || (m == MODE_SHL) || (m == MODE_ROR) ||
               (m == MODE_ROL) || (m == MODE_ASR);
    endfunction

endpackage

// File: rtl/shift_op_unit.sv
// ----------------------------------------------------------------------------
// shift_op_unit
// Purely combinational next-value generator for the shift register.
// Ports:
//   q      in  WIDTH  current register contents
//   op     in  3      operation select (univ_shift_pkg MODE_* encoding)
//   sin    in  1      serial input bit for SHR/SHL
//   d      in  WIDTH  parallel load data
//   nextQ  out WIDTH  register value after applying op once
// ----------------------------------------------------------------------------
module shift_op_unit
    import univ_shift_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] q,
    input  logic [2:0]       op,
    input  logic             sin,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] nextQ
);

    // One step of the selected operation; hold is the default so any
    // unlisted encoding leaves the register untouched.
    always_comb begin
        nextQ = q;
        case (op)
            MODE_SHR:  nextQ = {sin, q[WIDTH-1:1]};
            MODE_SHL:  nextQ = {q[WIDTH-2:0], sin};
            MODE_ROR:  nextQ = {q[0], q[WIDTH-1:1]};
            MODE_ROL:  nextQ = {q[WIDTH-2:0], q[WIDTH-1]};
            MODE_LOAD: nextQ = d;
            MODE_ASR:  nextQ = {q[WIDTH-1], q[WIDTH-1:1]};
            MODE_CLR:  nextQ = '0;
            default:   nextQ = q;
        endcase
    end

endmodule

// File: rtl/univ_shift_reg.sv
// ----------------------------------------------------------------------------
// univ_shift_reg
// Universal shift/rotate register with a burst engine that repeats a latched
// shift/rotate operation nshift times and then pulses done.
// Ports:
//   clk       in  1      rising-edge clock
//   reset     in  1      asynchronous, active-low reset
//   en        in  1      clock enable; 0 freezes q and burst progress
//   mode      in  3      operation select (MODE_* encoding)
//   d         in  WIDTH  parallel load data
//   sin       in  1      serial input bit
//   start     in  1      begin a burst of mode, repeated nshift times
//   nshift    in  NSH_W  burst operation count
//   q         out WIDTH  register contents
//   sout_lsb  out 1      q[0]
//   sout_msb  out 1      q[WIDTH-1]
//   busy      out 1      burst in progress (registered)
//   done      out 1      one-cycle burst-complete pulse (registered)
// ----------------------------------------------------------------------------
module univ_shift_reg
    import univ_shift_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int NSH_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [2:0]       mode,
    input  logic [WIDTH-1:0] d,
    input  logic             sin,
    input  logic             start,
    input  logic [NSH_W-1:0] nshift,
    output logic [WIDTH-1:0] q,
    output logic             sout_lsb,
    output logic             sout_msb,
    output logic             busy,
    output logic             done
);

    localparam logic [NSH_W-1:0] CNT_ONE = NSH_W'(1);

    state_t           state;
    state_t           stateNext;
    logic [NSH_W-1:0] cnt;
    logic [NSH_W-1:0] cntNext;
    logic [2:0]       opReg;
    logic [2:0]       opRegNext;
    logic [2:0]       opSel;
    logic [WIDTH-1:0] qNext;
    logic [WIDTH-1:0] opResult;

    // During a burst the latched op drives the datapath so that mode changes
    // on the inputs cannot disturb a running burst.
    always_comb begin
        opSel = mode;
        if (state == ST_RUN) begin
            opSel = opReg;
        end
    end

    shift_op_unit #(
        .WIDTH (WIDTH)
    ) u_op (
        .q     (q),
        .op    (opSel),
        .sin   (sin),
        .d     (d),
        .nextQ (opResult)
    );

    // Next-state logic. In IDLE a start with a repeatable op only latches
    // the op and count; the start cycle itself never shifts. Any other IDLE
    // cycle with en=1 is a manual op. DONE lasts exactly one cycle whatever
    // en does, and q holds there.
    always_comb begin
        stateNext = state;
        cntNext   = cnt;
        opRegNext = opReg;
        qNext     = q;
        case (state)
            ST_IDLE: begin
                if (en) begin
                    if (start && is_burst_op(mode)) begin
                        opRegNext = mode;
                        cntNext   = nshift;
                        stateNext = (nshift != '0) ? ST_RUN : ST_DONE;
                    end else begin
                        qNext = opResult;
                    end
                end
            end
            ST_RUN: begin
                if (en) begin
                    qNext   = opResult;
                    cntNext = cnt - CNT_ONE;
                    if (cnt == CNT_ONE) begin
                        stateNext = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                stateNext = ST_IDLE;
            end
            default: begin
                stateNext = ST_IDLE;
            end
        endcase
    end

    // All state lives here. busy/done are registered from the next state so
    // they change on the same edge as the FSM and can never overlap.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ST_IDLE;
            cnt   <= '0;
            opReg <= MODE_HOLD;
            q     <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= stateNext;
            cnt   <= cntNext;
            opReg <= opRegNext;
            q     <= qNext;
            busy  <= (stateNext == ST_RUN);
            done  <= (stateNext == ST_DONE);
        end
    end

    assign sout_lsb = q[0];
    assign sout_msb = q[WIDTH-1];

endmodule

// File: doc/univ_shift_reg.md
Name: univ_shift_reg

Overview:
Parametrised universal shift/rotate register, the successor to the single-bit asynchronous-reset flip-flop.
- Manual mode: one operation per enabled clock, covering hold, logical shift, arithmetic shift, rotate, parallel load and synchronous clear.
- Burst mode: an internal FSM repeats a latched shift/rotate operation N times, then reports completion.
- Used in the datapath as a serialiser, deserialiser and barrel-shift substitute.

Parameters:
- WIDTH, 8, register width in bits (>=2).
- NSH_W, 4, width of the burst shift-count input; a burst may run up to 2^NSH_W-1 operations.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- en  in  1  clock enable; 0 freezes q and burst progress.
- mode  in  3  operation select (encoding below).
- d  in  WIDTH  parallel load data.
- sin  in  1  serial input bit.
- start  in  1  begin a burst of mode op, repeated nshift times.
- nshift  in  NSH_W  burst operation count.
- q  out  WIDTH  register contents.
- sout_lsb  out  1  equals q[0] (combinational from q).
- sout_msb  out  1  equals q[WIDTH-1] (combinational from q).
- busy  out  1  burst in progress.
- done  out  1  single-cycle burst-complete pulse.

Behaviour:
- Reset: one clock; reset is asynchronous, active-low. While reset=0: q=0, FSM=IDLE, busy=0, done=0, internal count=0. This takes effect immediately, not at the next edge.
- Mode encoding:
  - 000 hold.
  - 001 SHR: q <= {sin, q[W-1:1]}.
  - 010 SHL: q <= {q[W-2:0], sin}.
  - 011 ROR: q <= {q[0], q[W-1:1]}.
  - 100 ROL: q <= {q[W-2:0], q[W-1]}.
  - 101 LOAD: q <= d.
  - 110 ASR: q <= {q[W-1], q[W-1:1]}.
  - 111 CLR: q <= 0.
- Manual operation (IDLE, start=0): when en=1, the selected op is applied at the clock edge, so the result is visible one cycle later. When en=0, q holds.
- FSM states and transitions:
  - IDLE: start=1 and en=1 and mode in {001,010,011,100,110} → latch op=mode and cnt=nshift.
    - If nshift≠0, go to RUN; the start cycle itself performs no op.
    - If nshift=0, go to DONE; q is unchanged.
  - IDLE, start=1 with mode in {000,101,111}: start is ignored and the mode is executed as a manual op.
  - RUN: busy=1. Each en=1 cycle applies the latched op and decrements cnt. When the op is applied with cnt==1, go to DONE. en=0 stalls, holding both q and cnt.
  - RUN: mode, start, d and nshift inputs are ignored; sin is still sampled every shifting cycle (SHR/SHL).
  - DONE: done=1 and busy=0 for exactly one cycle; q holds and start is ignored. Then go to IDLE unconditionally, regardless of en.
- Latency: a burst of N operations with en held high gives busy high for N cycles starting the cycle after start, then done high for 1 cycle. Each en=0 cycle during RUN extends busy by one cycle.
- Boundaries:
  - nshift > WIDTH is legal: rotates wrap fully, and shifts saturate to all-sin or all-sign.
  - Reset asserted mid-burst aborts the burst with no done pulse.
  - start held high continuously does not retrigger until the FSM returns to IDLE.
  - busy and done are registered outputs and are never high simultaneously.

Decomposition:
- Package univ_shift_pkg:
  - 3-bit mode localparams (MODE_HOLD … MODE_CLR).
  - FSM state encoding (ST_IDLE, ST_RUN, ST_DONE).
  - Function is_burst_op(mode).
- Sub-module shift_op_unit: purely combinational; (q, op, sin, d) → next_q.
  - The FSM wrapper holds the only sequential logic: q register, cnt, state.

Test Plan (WIDTH=8):
1. Pulse reset low mid-cycle with q=0x5A and busy=1 → q=0x00, busy=0, done=0 before the next clk edge; values stay there until reset is released.
2. Manual ops, en=1:
   - LOAD d=0xA5 → q=0xA5.
   - SHR sin=1 → 0xD2.
   - SHL sin=0 → 0xA4.
   - LOAD 0xA5 then ROR → 0xD2.
   - LOAD 0x85 then ASR → 0xC2.
   - CLR → 0x00.
   - With en=0, any mode → q unchanged.
3. Burst: LOAD 0x81, then start with mode=ROL, nshift=3 → busy=1 for 3 cycles with q sequence 0x03, 0x06, 0x0C; then done=1 for 1 cycle; then IDLE.
4. Same burst as 3 with en=0 for 2 cycles mid-RUN, and mode/start toggled during RUN → busy lasts 5 cycles, final q=0x0C, inputs ignored, a single done pulse.
5. Start cases:
   - start with nshift=0, mode=SHR → done next cycle, busy never high, q unchanged.
   - start with mode=LOAD → no burst; q<=d.
6. Burst nshift=10 mode=ROR on 0x01 → final q=0x40 (rotate wraps). Reset asserted at 4th RUN cycle → q=0, no done pulse after reset release.
